cacheline_adaptor: RTL
======================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 256, cache line width in bits.
REQ-002 SHALL have parameter BURST_WIDTH, default 64, memory beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH (4).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port line_i  input  LINE_WIDTH  write line from cache.
REQ-006 SHALL have port line_o  output  LINE_WIDTH  assembled read line to cache.
REQ-007 SHALL have port address_i  input  32  line address from cache.
REQ-008 SHALL have port read_i  input  1  cache line read request, held until resp_o.
REQ-009 SHALL have port write_i  input  1  cache line write request, held until resp_o.
REQ-010 SHALL have port resp_o  output  1  one-cycle completion pulse to cache.
REQ-011 SHALL have port burst_i  input  BURST_WIDTH  read beat from burst memory (mem_rdata).
REQ-012 SHALL have port burst_o  output  BURST_WIDTH  write beat to burst memory (mem_wdata).
REQ-013 SHALL have port address_o  output  32  burst address (mem_addr).
REQ-014 SHALL have port read_o  output  1  burst read request (mem_read).
REQ-015 SHALL have port write_o  output  1  burst write request (mem_write).
REQ-016 SHALL have port resp_i  input  1  per-beat memory response (mem_resp).
REQ-017 SHALL have ports rd_count_o, wr_count_o  output  32 each  completed-transaction counters.

Function
REQ-018 SHALL implement FSM states IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE with a 2-bit beat counter.
REQ-019 IDLE: write_i=1 -> WR_BURST; else read_i=1 -> RD_BURST; simultaneous read_i/write_i SHALL be treated as write.
REQ-020 On acceptance SHALL latch address_i with bits [4:0] cleared into address_o, latch line_i for writes, and clear the beat counter.
REQ-021 read_o SHALL be 1 exactly in RD_BURST; write_o exactly in WR_BURST; both registered-state decoded, glitch-free.
REQ-022 RD_BURST: each cycle with resp_i=1 SHALL capture burst_i into line beat [counter] (beat 0 = bits 63:0) and increment counter; after beat 3 -> RD_DONE.
REQ-023 WR_BURST: burst_o SHALL present latched line beat [counter]; each resp_i=1 SHALL increment counter; after beat 3 -> WR_DONE.
REQ-024 RD_DONE/WR_DONE: resp_o=1 for exactly one cycle, line_o valid that cycle, then -> IDLE.
REQ-025 Read latency: resp_o SHALL assert the cycle after the 4th resp_i beat; same for write.
REQ-026 resp_i gaps (0 cycles between beats) SHALL stall the counter without data loss; resp_i in IDLE/DONE states SHALL be ignored.
REQ-027 line_o SHALL hold its last assembled value until the next read completes; burst_o SHALL be 0 outside WR_BURST.
REQ-028 A new request SHALL be accepted no earlier than the cycle after resp_o; address_i/line_i changes mid-transaction SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, counter 0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0, counters 0.
REQ-030 Reset mid-burst SHALL abandon the transaction with no resp_o; partial line data SHALL be discarded.

Configuration
REQ-031 With CACHELINE_ADAPTOR_PERF_EN defined, rd_count_o/wr_count_o SHALL increment on each resp_o of a read/write, wrapping 0xFFFFFFFF -> 0.
REQ-032 Without CACHELINE_ADAPTOR_PERF_EN, rd_count_o and wr_count_o SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-033 read_i=1, address_i=0x0000_1234, resp_i 4 consecutive cycles with burst_i=0x11..,0x22..,0x33..,0x44.. -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o one cycle after 4th beat.
REQ-034 write_i=1, line_i=256'hDDDD..CCCC..BBBB..AAAA -> burst_o sequence 0xAAAA..,0xBBBB..,0xCCCC..,0xDDDD.. on successive resp_i, write_o drops and resp_o pulses once.
REQ-035 read with resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, resp_o once.
REQ-036 read_i=write_i=1 together -> write burst only, read_o never asserted.
REQ-037 rst asserted after 2 read beats -> read_o=0 same cycle, no resp_o; next read completes correctly.
REQ-038 PERF_EN build: 3 reads, 2 writes -> rd_count_o=3, wr_count_o=2; counter preloaded 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Cache-line to burst-memory adaptor: splits a line write into BEATS memory beats and assembles BEATS read beats into a line.
// Optional transaction counters are enabled with `define CACHELINE_ADAPTOR_PERF_EN.
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i,
    output logic [31:0]            rd_count_o,
    output logic [31:0]            wr_count_o
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DONE  = 3'd2,
        WR_BURST = 3'd3,
        WR_DONE  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wr_buf_q, wr_buf_d;
    logic [LINE_WIDTH-1:0]   rd_buf_q, rd_buf_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic [BURST_WIDTH-1:0]  burst_q, burst_d;
    logic                    read_q, read_d;
    logic                    write_q, write_d;
    logic                    resp_q, resp_d;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_buf_d = wr_buf_q;
        rd_buf_d = rd_buf_q;
        line_d   = line_q;

        case (state_q)
            IDLE: begin
                // Line aligned address: the low five bits select a byte inside the line.
                if (write_i) begin
                    state_d  = WR_BURST;
                    addr_d   = address_i & 32'hFFFF_FFE0;
                    wr_buf_d = line_i;
                    cnt_d    = '0;
                end else if (read_i) begin
                    state_d  = RD_BURST;
                    addr_d   = address_i & 32'hFFFF_FFE0;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    rd_buf_d[int'(cnt_q) * BURST_WIDTH +: BURST_WIDTH] = burst_i;
                    cnt_d = cnt_q + CNT_W'(1);
                    // line_o only changes once a whole line has arrived.
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RD_DONE;
                        line_d  = rd_buf_d;
                    end else begin
                        state_d = RD_BURST;
                    end
                end else begin
                    state_d = RD_BURST;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            WR_BURST: begin
                if (resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = WR_DONE;
                    end else begin
                        state_d = WR_BURST;
                    end
                end else begin
                    state_d = WR_BURST;
                end
            end
            WR_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they leave a flop cleanly.
        read_d  = (state_d == RD_BURST);
        write_d = (state_d == WR_BURST);
        resp_d  = (state_d == RD_DONE) || (state_d == WR_DONE);
        if (state_d == WR_BURST) begin
            burst_d = wr_buf_d[int'(cnt_d) * BURST_WIDTH +: BURST_WIDTH];
        end else begin
            burst_d = '0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= 32'd0;
            wr_buf_q <= '0;
            rd_buf_q <= '0;
            line_q   <= '0;
            burst_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            resp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wr_buf_q <= wr_buf_d;
            rd_buf_q <= rd_buf_d;
            line_q   <= line_d;
            burst_q  <= burst_d;
            read_q   <= read_d;
            write_q  <= write_d;
            resp_q   <= resp_d;
        end
    end

    assign line_o    = line_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    // Count each completed transaction during its resp_o cycle; wraps naturally.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == RD_DONE) begin
            rd_count_d = rd_count_q + 32'd1;
        end else if (state_q == WR_DONE) begin
            wr_count_d = wr_count_q + 32'd1;
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    // Transaction counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;
`else
    assign rd_count_o = 32'd0;
    assign wr_count_o = 32'd0;
`endif

endmodule
